// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl - table-driven IO bus controller between the CPU bus and NUM_DEV
// IO devices. Decodes the IO word address into one-hot device strobes, muxes
// device ack/read data back to the CPU, acknowledges unmapped accesses itself,
// forces an ack after TIMEOUT cycles without a device ack, and keeps a sticky
// error/status register readable (and clearable by any write) at STAT_SLOT.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   io_stb            CPU strobe qualified to the IO region, held until ack
//   bus_we            write enable of the current access
//   bus_addr[5:0]     IO word address (CPU bus_addr[7:2])
//   data_in[31:0]     CPU write data (status register only)
//   dev_dout          packed device read data, device i at [32i+31:32i]
//   dev_ack           device acks
//   dev_stb           one-hot device strobes
//   data_out[31:0]    read data to the CPU
//   ack               bus ack to the CPU
//   err               sticky error flag
//   err_trig          one-cycle pulse following each error event
module io_bus_ctrl #(
  parameter int unsigned          NUM_DEV   = 12,
  parameter logic [NUM_DEV*6-1:0] DEV_BASE  = '0,
  parameter logic [NUM_DEV*6-1:0] DEV_MASK  = '1,
  parameter int unsigned          TIMEOUT   = 1023,
  parameter logic [5:0]           STAT_SLOT = 6'h2E
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    io_stb,
  input  logic                    bus_we,
  input  logic [5:0]              bus_addr,
  input  logic [31:0]             data_in,
  input  logic [NUM_DEV*32-1:0]   dev_dout,
  input  logic [NUM_DEV-1:0]      dev_ack,
  output logic [NUM_DEV-1:0]      dev_stb,
  output logic [31:0]             data_out,
  output logic                    ack,
  output logic                    err,
  output logic                    err_trig
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TCNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    KIND_NONE     = 2'b00,
    KIND_TIMEOUT  = 2'b01,
    KIND_UNMAPPED = 2'b10
  } err_kind_e;

  // Write data carries no information: any write to the status slot clears it.
  logic data_in_unused;
  assign data_in_unused = ^data_in;

  logic               stat_hit;
  logic               dev_hit;
  logic               unmapped;
  logic [NUM_DEV-1:0] sel_oh;
  logic               sel_ack;
  logic [31:0]        sel_dout;
  logic               tmo;
  logic               err_evt;
  logic               stat_wr;

  logic [CW-1:0]      tcnt;
  logic [7:0]         e_cnt;
  err_kind_e          e_kind;
  logic               e_we;
  logic [5:0]         e_addr;
  logic [31:0]        stat_word;

  // Address decode: status slot first, then lowest matching device index.
  always_comb begin
    stat_hit = io_stb && (bus_addr == STAT_SLOT);
    dev_hit  = 1'b0;
    sel_oh   = '0;
    sel_ack  = 1'b0;
    sel_dout = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (!dev_hit &&
          ((bus_addr & DEV_MASK[6*i +: 6]) == (DEV_BASE[6*i +: 6] & DEV_MASK[6*i +: 6]))) begin
        dev_hit   = 1'b1;
        sel_oh[i] = 1'b1;
        sel_ack   = dev_ack[i];
        sel_dout  = dev_dout[32*i +: 32];
      end
    end
    dev_hit  = dev_hit && io_stb && !stat_hit;
    unmapped = io_stb && !stat_hit && !dev_hit;
    // A device ack in the last allowed cycle takes precedence over the timeout.
    tmo      = dev_hit && !sel_ack && (tcnt == TCNT_LAST);
    err_evt  = unmapped || tmo;
    stat_wr  = stat_hit && bus_we;
  end

  assign stat_word = {e_cnt, 8'h00, e_kind, e_we, 5'b00000, e_addr, 2'b00};

  // Bus response mux.
  always_comb begin
    dev_stb  = '0;
    ack      = 1'b0;
    data_out = '0;
    if (stat_hit) begin
      ack      = 1'b1;
      data_out = stat_word;
    end else if (dev_hit) begin
      dev_stb  = sel_oh;
      ack      = sel_ack || tmo;
      data_out = tmo ? 32'h0 : sel_dout;
    end else if (unmapped) begin
      ack      = 1'b1;
    end
  end

  // Timeout counter: counts waiting cycles of a device access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (!io_stb || ack) begin
      tcnt <= '0;
    end else if (dev_hit && !sel_ack) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Sticky status register and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_cnt    <= '0;
      e_kind   <= KIND_NONE;
      e_we     <= 1'b0;
      e_addr   <= '0;
      err      <= 1'b0;
      err_trig <= 1'b0;
    end else begin
      err_trig <= err_evt;
      if (stat_wr) begin
        e_cnt  <= '0;
        e_kind <= KIND_NONE;
        e_we   <= 1'b0;
        e_addr <= '0;
        err    <= 1'b0;
      end else if (err_evt) begin
        err    <= 1'b1;
        e_kind <= unmapped ? KIND_UNMAPPED : KIND_TIMEOUT;
        e_we   <= bus_we;
        e_addr <= bus_addr;
        if (e_cnt != 8'hFF) begin
          e_cnt <= e_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Randomised scoreboard bench for io_bus_ctrl with TIMEOUT = 16 and a small
// device map containing overlapping and status-shadowing entries.
module tb_io_bus_ctrl;

  localparam int unsigned NUM_DEV = 12;
  localparam int unsigned TMO     = 16;
  localparam logic [5:0]  STAT    = 6'h2E;
  // device 11 .. device 0
  localparam logic [NUM_DEV*6-1:0] BASE = {6'h00, 6'h00, 6'h00, 6'h00,
                                           6'h20, 6'h00, 6'h24, 6'h00,
                                           6'h31, 6'h2C, 6'h10, 6'h00};
  localparam logic [NUM_DEV*6-1:0] MASK = {6'h3F, 6'h3F, 6'h3F, 6'h3F,
                                           6'h38, 6'h3F, 6'h3F, 6'h3F,
                                           6'h3F, 6'h3C, 6'h30, 6'h3F};

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  io_stb = 1'b0;
  logic                  bus_we = 1'b0;
  logic [5:0]            bus_addr = '0;
  logic [31:0]           data_in = '0;
  logic [NUM_DEV*32-1:0] dev_dout;
  logic [NUM_DEV-1:0]    dev_ack;
  logic [NUM_DEV-1:0]    dev_stb;
  logic [31:0]           data_out;
  logic                  ack;
  logic                  err;
  logic                  err_trig;

  io_bus_ctrl #(
    .NUM_DEV(NUM_DEV), .DEV_BASE(BASE), .DEV_MASK(MASK),
    .TIMEOUT(TMO), .STAT_SLOT(STAT)
  ) dut (
    .clk(clk), .rst(rst), .io_stb(io_stb), .bus_we(bus_we),
    .bus_addr(bus_addr), .data_in(data_in), .dev_dout(dev_dout),
    .dev_ack(dev_ack), .dev_stb(dev_stb), .data_out(data_out),
    .ack(ack), .err(err), .err_trig(err_trig)
  );

  always #5 clk = ~clk;

  // Device models: device i acks after lat[i] waiting cycles of its strobe.
  int unsigned lat    [NUM_DEV];
  logic [31:0] dout_a [NUM_DEV];
  int unsigned dcnt   [NUM_DEV];

  always_comb begin
    for (int i = 0; i < NUM_DEV; i++) begin
      dev_ack[i]           = dev_stb[i] && (dcnt[i] >= lat[i]);
      dev_dout[32*i +: 32] = dout_a[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NUM_DEV; i++)
      dcnt[i] <= (dev_stb[i] && !dev_ack[i]) ? dcnt[i] + 1 : 0;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model of the status register.
  logic [7:0] m_cnt;
  logic [1:0] m_kind;
  logic       m_we;
  logic [5:0] m_addr;
  logic       m_err;

  task automatic m_clear();
    m_cnt = '0; m_kind = '0; m_we = 1'b0; m_addr = '0; m_err = 1'b0;
  endtask

  task automatic m_record(input logic [1:0] k, input logic we, input logic [5:0] a);
    m_err = 1'b1; m_kind = k; m_we = we; m_addr = a;
    if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
  endtask

  function automatic logic [31:0] m_word();
    return {m_cnt, 8'h00, m_kind, m_we, 5'b00000, m_addr, 2'b00};
  endfunction

  function automatic int ref_sel(input logic [5:0] a);
    logic [5:0] b, m;
    for (int i = 0; i < NUM_DEV; i++) begin
      b = BASE[6*i +: 6];
      m = MASK[6*i +: 6];
      if ((a & m) == (b & m)) return i;
    end
    return -1;
  endfunction

  typedef struct {
    logic [31:0]        data;
    int unsigned        cyc;
    logic [NUM_DEV-1:0] stb;
    logic               evt;
    logic               err_after;
  } exp_t;

  exp_t q[$];

  // Issue one access (called 1 time unit after a rising edge); returns read data.
  task automatic access(input logic [5:0] a, input logic we, input int unsigned l,
                        output logic [31:0] rd);
    exp_t e;
    int   s;
    bit   got_ack;
    s = ref_sel(a);
    e.stb = '0;
    e.evt = 1'b0;
    if (a == STAT) begin
      e.data = m_word();
      e.cyc  = 1;
      if (we) m_clear();
    end else if (s < 0) begin
      e.data = 32'h0;
      e.cyc  = 1;
      e.evt  = 1'b1;
      m_record(2'b10, we, a);
    end else begin
      lat[s]   = l;
      e.stb[s] = 1'b1;
      if (l + 1 <= TMO) begin
        e.data = dout_a[s];
        e.cyc  = l + 1;
      end else begin
        e.data = 32'h0;
        e.cyc  = TMO;
        e.evt  = 1'b1;
        m_record(2'b01, we, a);
      end
    end
    e.err_after = m_err;
    q.push_back(e);
    bus_addr = a;
    bus_we   = we;
    data_in  = $urandom;
    io_stb   = 1'b1;
    got_ack  = 1'b0;
    for (int n = 0; n < 64 && !got_ack; n++) begin
      @(negedge clk);
      got_ack = ack;
    end
    rd = data_out;
    if (!got_ack) begin
      chk("ack_wait_expired", 32'(ack), 32'h1);
      q.delete();
    end
    @(posedge clk); #1;
    io_stb = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: compares every acknowledged access against the scoreboard.
  int unsigned mcyc;
  bit          chk_next;
  logic        nxt_evt, nxt_err;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      mcyc     = 0;
      chk_next = 0;
    end else begin
      if (chk_next) begin
        chk("err_trig_after_ack", 32'(err_trig), 32'(nxt_evt));
        chk("err_after_ack", 32'(err), 32'(nxt_err));
        chk_next = 0;
      end else begin
        chk("err_trig_idle", 32'(err_trig), 32'h0);
      end
      if (io_stb) begin
        mcyc++;
        if (q.size() == 0) begin
          if (ack) chk("unexpected_ack", 32'(ack), 32'h0);
        end else begin
          chk("dev_stb", 32'(dev_stb), 32'(q[0].stb));
          if (ack) begin
            e = q.pop_front();
            chk("data_out", data_out, e.data);
            chk("ack_cycle", mcyc, e.cyc);
            chk_next = 1;
            nxt_evt  = e.evt;
            nxt_err  = e.err_after;
          end
        end
      end else begin
        mcyc = 0;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic [5:0]  ra;
  int unsigned rl;

  initial begin : stim
    for (int i = 0; i < NUM_DEV; i++) begin
      lat[i]    = 255;
      dout_a[i] = $urandom;
    end
    dout_a[3] = 32'hCAFE0003;
    m_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_dev_stb", 32'(dev_stb), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_err_trig", 32'(err_trig), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    access(STAT, 1'b0, 0, rd);
    chk("rst_status", rd, 32'h0);

    // Device 3, two wait cycles.
    access(6'h31, 1'b0, 2, rd);
    chk("dev3_data", rd, 32'hCAFE0003);
    chk("dev3_err", 32'(err), 32'h0);

    // Unmapped read then status read.
    access(6'h05, 1'b0, 0, rd);
    chk("unmapped_data", rd, 32'h0);
    chk("unmapped_err", 32'(err), 32'h1);
    access(STAT, 1'b0, 0, rd);
    chk("unmapped_status", rd, 32'h01008014);
    access(STAT, 1'b1, 0, rd);

    // Timeout on a write to slot 0x24 (device 5, never acks).
    access(6'h24, 1'b1, 255, rd);
    chk("timeout_data", rd, 32'h0);
    access(STAT, 1'b0, 0, rd);
    chk("timeout_status", rd, 32'h01006090);
    access(STAT, 1'b1, 0, rd);

    // Device acks in the last allowed cycle.
    access(6'h24, 1'b0, TMO - 1, rd);
    chk("late_ack_data", rd, dout_a[5]);
    chk("late_ack_err", 32'(err), 32'h0);

    // Error counter saturation and clear.
    for (int i = 0; i < 300; i++) access(6'h05, 1'b0, 0, rd);
    access(STAT, 1'b0, 0, rd);
    chk("sat_status", rd, 32'hFF008014);
    access(STAT, 1'b1, 0, rd);
    access(STAT, 1'b0, 0, rd);
    chk("cleared_status", rd, 32'h0);
    chk("cleared_err", 32'(err), 32'h0);

    // Reset in cycle 5 of a pending access, then re-issue it.
    lat[5]   = 255;
    bus_addr = 6'h24;
    bus_we   = 1'b0;
    io_stb   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ack", 32'(ack), 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    @(posedge clk); #1;
    io_stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_clear();
    @(posedge clk); #1;
    chk("postrst_err", 32'(err), 32'h0);
    access(6'h24, 1'b0, 255, rd);
    chk("postrst_timeout_data", rd, 32'h0);

    // Randomised traffic.
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 5))
        0: ra = 6'h31;
        1: ra = 6'h24;
        2: ra = 6'h00;
        3: ra = STAT;
        4: ra = 6'($urandom_range(32'h20, 32'h2F));
        default: ra = 6'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: rl = 0;
        1: rl = 1;
        2: rl = 2;
        3: rl = 3;
        4: rl = TMO - 2;
        5: rl = TMO - 1;
        6: rl = TMO;
        default: rl = 255;
      endcase
      access(ra, 1'($urandom), rl, rd);
    end
    access(STAT, 1'b0, 0, rd);
    chk("final_status", rd, m_word());

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus_ctrl.md
# io_bus_ctrl

Parametrised IO bus controller between the CPU bus and the IO devices of the RISC5 platforms. It replaces per-design hand-written IO strobe decoding and data/ack multiplexing with a table-driven decoder for `NUM_DEV` devices. It also adds behaviour the hand-written version lacks: bus timeout, unmapped-address acknowledge, and a sticky error/status register readable at its own IO slot. Its outputs feed the red LEDs and the reset trigger logic.

## Interface

Parameters:
- `NUM_DEV`, 12: number of device ports.
- `DEV_BASE`, all 0: packed `NUM_DEV`×6 bits; slot base word address (`bus_addr[7:2]`) of device i at bits [6i+5:6i].
- `DEV_MASK`, all 6'h3F: packed `NUM_DEV`×6 bits; device i matches when `(addr & mask_i) == (base_i & mask_i)`.
- `TIMEOUT`, 1023: cycles waited for a device ack; range 2..65535.
- `STAT_SLOT`, 6'h2E: word slot of the status register, byte offset 0xB8 (-72).

Ports:
- `clk` in, 1: system clock.
- `rst` in, 1: reset, asynchronous, active-high.
- `io_stb` in, 1: CPU strobe already qualified to the IO region; held until `ack`.
- `bus_we` in, 1: write enable.
- `bus_addr` in, 6: word address within the IO region (CPU `bus_addr[7:2]`).
- `data_in` in, 32: CPU write data, used by the status register only.
- `dev_dout` in, `NUM_DEV`×32: device read data, device i at [32i+31:32i].
- `dev_ack` in, `NUM_DEV`: device acks.
- `dev_stb` out, `NUM_DEV`: one-hot device strobes.
- `data_out` out, 32: read data to the CPU.
- `ack` out, 1: bus ack to the CPU.
- `err` out, 1: sticky error flag.
- `err_trig` out, 1: one-cycle pulse per error event.

## Operation

Decode (combinational from `io_stb` and `bus_addr`):
- `STAT_SLOT` has top priority.
- Among the devices, the lowest matching index wins.
- `dev_stb` carries at most one bit.
- No match and not `STAT_SLOT`: the access is unmapped.

Ack and data by access type:
- Device: `ack` = selected `dev_ack`; `data_out` = selected `dev_dout`.
- Status slot: `ack` = 1 in the same cycle. `data_out` = status word. A write (`bus_we`) clears all status fields and `err` at the clock edge.
- Unmapped: `ack` = 1 in the same cycle; `data_out` = 0; error kind 2'b10.
- Timeout: `ack` forced to 1 with `data_out` = 0; error kind 2'b01.
- `io_stb` low: `ack` = 0, `data_out` = 0, `dev_stb` = 0.

Timeout counter:
- Width clog2(`TIMEOUT`).
- Increments each cycle in which `io_stb` = 1, a device is selected, and its `dev_ack` = 0.
- Clears when `io_stb` = 0 or `ack` = 1.
- When count = `TIMEOUT`-1 and `dev_ack` = 0, the controller forces `ack` in that cycle, which is the `TIMEOUT`-th cycle of the access.
- If the device ack arrives in that same cycle, the device wins: its data is returned and no error is recorded.
- If the CPU drops `io_stb` without an ack, the counter clears and no error is recorded.

Error event (timeout or unmapped, recorded at the edge where `io_stb` & `ack`):
- `err` ← 1.
- `err_trig` = 1 for exactly the following cycle.
- Kind, we, and address are overwritten with the latest error.
- Count increments and saturates at 255.

Status word:
- [31:24] error count.
- [23:16] 0.
- [15:14] kind.
- [13] we of the failed access.
- [12:8] 0.
- [7:0] byte offset = {addr, 2'b00}.

## Timing

- Reset (asynchronous): counter = 0, status = 0, `err` = 0, `err_trig` = 0. `ack`, `data_out`, and `dev_stb` are 0 while `io_stb` = 0. A reset during a pending access clears everything immediately.
- Device path is pass-through with no added latency; device latency equals `dev_ack` delay.
- Status and unmapped accesses complete in one cycle.
- Timeout completes in `TIMEOUT` cycles from the `io_stb` rise.
- A status write and an error event cannot coincide (single bus master).
- `err_trig` lags the erroring ack edge by one cycle.

## Test plan

1. Defaults with device 3 at base 6'h31, mask 6'h3F, `dev_ack`[3] after 2 cycles, `dev_dout`[3] = 0xCAFE0003 -> `dev_stb` = 1<<3 only; `ack` in cycle 3 with data 0xCAFE0003; `err` = 0.
2. Read unmapped slot 6'h05 -> `ack` in the same cycle, data 0; `err` = 1; `err_trig` high for 1 cycle; then status read -> 0x01008014.
3. `TIMEOUT` = 16, selected device never acks, write access to slot 6'h24 -> `ack` in cycle 16, data 0; status -> 0x010060 90 (count 1, kind 01, we 1, offset 0x90) i.e. 0x01006090.
4. `TIMEOUT` = 16, device acks exactly in cycle 16 -> device data returned; `err` stays 0; `err_trig` never pulses.
5. Force 300 unmapped reads -> count field = 0xFF; write 0 to `STAT_SLOT` -> status reads 0x00000000; `err` = 0.
6. Assert `rst` in cycle 5 of a pending device access (`TIMEOUT` = 16), deassert, re-issue the access -> timeout again occurs at cycle 16 of the new access, not earlier; `err` = 0 before it.
